// File: rtl/minterm_scanner_if.sv
// minterm_scanner_if
//   Valid/ready stream that carries minterm indices from the scanner to a consumer.
//   m_valid  : index valid (driven by master)
//   m_ready  : consumer accepts m_index when m_valid & m_ready (driven by slave)
//   m_index  : minterm index, N_IN bits (driven by master)
interface minterm_scanner_if #(
    parameter int N_IN = 3
) ();
    logic            m_valid;
    logic            m_ready;
    logic [N_IN-1:0] m_index;

    modport master (
        output m_valid,
        output m_index,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/minterm_scanner.sv
// minterm_scanner
//   Sweeps every input code of an external combinational function, holds each code
//   for SETTLE cycles, samples f_in on the last of them and streams out every code
//   where f=1 as a minterm index. m_count ends up holding the number of minterms.
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : 1-cycle sweep request, only honoured in IDLE
//   fx_out   : code driven to the function under test (MSB = first variable)
//   f_in     : function output read back
//   m_count  : minterms accepted so far / final total (N_IN+1 bits, never wraps)
//   busy     : high while sweeping (SETTLE and EMIT)
//   done     : 1-cycle pulse when the sweep completes
//   m        : minterm index stream (master side)
module minterm_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   fx_out,
    input  logic              f_in,
    output logic [N_IN:0]     m_count,
    output logic              busy,
    output logic              done,
    minterm_scanner_if.master m
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int              CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] CODE_LAST = {N_IN{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic            valid_q;
    logic [N_IN-1:0] index_q;
    logic            armed;
    logic            last_code;

    assign last_code = (fx_out == CODE_LAST);

    assign m.m_valid = valid_q;
    assign m.m_index = index_q;
    assign busy      = (state == S_SETTLE) || (state == S_EMIT);
    assign done      = (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every register sees the
    // values from before the edge; blocking here would chain updates within a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fx_out  <= '0;
            m_count <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            armed   <= 1'b0;
        end else begin
            // armed stays low for the first edge after reset release, so a start
            // presented on that very edge is ignored.
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        fx_out  <= '0;
                        m_count <= '0;
                        cnt     <= '0;
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        if (f_in) begin
                            valid_q <= 1'b1;
                            index_q <= fx_out;
                            state   <= S_EMIT;
                        end else begin
                            // Advance: finish on the all-ones code, never wrap.
                            cnt   <= '0;
                            state <= last_code ? S_DONE : S_SETTLE;
                            if (!last_code) fx_out <= fx_out + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    // Everything is frozen until the consumer takes the index.
                    if (m.m_ready) begin
                        m_count <= m_count + 1'b1;
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        state   <= last_code ? S_DONE : S_SETTLE;
                        if (!last_code) fx_out <= fx_out + 1'b1;
                    end
                end
                default: begin
                    // S_DONE: single-cycle pulse, results held for the reader.
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
